dbus_scratchpad_responder: RTL and testbench

- Responder end of the dbus req/resp handshake: it sits where the data cache or bridge normally connects and answers `dbus_req_t` with `dbus_resp_t`.
- Backed by an internal word-addressed RAM, with a programmable, in-order response latency and a bounded outstanding-request queue.
- Used as a stand-in data memory for core/MMU bring-up and as a protocol-compliant target in block benches.

---
 rtl/dbus_scratchpad_responder.sv | 133 +++++++++++++
 tb/tb_dbus_scratchpad_responder.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/dbus_scratchpad_responder.sv
// dbus responder backed by a 2**AW-word RAM; DBUS_RESPONDER_RANDOM_STALL_EN adds LFSR accept stalls.
// Latency: data_ok LATENCY cycles after an accept into an empty queue (or after the predecessor's pop).
// Backpressure: addr_ok drops while QDEPTH requests are outstanding; data_ok cannot be stalled.
module dbus_scratchpad_responder #(
    parameter int AW      = 10,
    parameter int LATENCY = 2,
    parameter int QDEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [71:0]                dreq,
    output logic [33:0]                dresp,
    output logic [$clog2(QDEPTH):0]    pending
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;

    // Packed bus layouts, MSB first.
    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [3:0]  strobe;
        logic [31:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } dbus_resp_t;

    dbus_req_t      req;
    dbus_resp_t     resp;

    logic [31:0]    ram [0:(1 << AW) - 1];
    logic [31:0]    q_dat [0:QDEPTH - 1];
    logic [PW-1:0]  wptr;
    logic [PW-1:0]  rptr;
    logic [CW-1:0]  count;
    logic [3:0]     timer;

    logic [AW-1:0]  widx;
    logic [31:0]    entry_dat;
    logic           stall_ok;
    logic           addr_ok;
    logic           data_ok;
    logic           is_write;
    logic           unused_bits;

    assign req         = dbus_req_t'(dreq);
    assign widx        = req.addr[AW+1:2];
    assign is_write    = (req.strobe != 4'h0);
    assign unused_bits = ^{req.size, req.addr[1:0], req.addr[31:AW+2]};

`ifdef DBUS_RESPONDER_RANDOM_STALL_EN
    logic [7:0] lfsr;

    // Fibonacci LFSR, x^8 + x^6 + x^5 + x^4 + 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr <= 8'hA5;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    assign stall_ok = lfsr[0];
`else
    assign stall_ok = 1'b1;
`endif

    // No bypass: a pop in the same cycle does not free a slot for this cycle's push.
    always_comb begin
        addr_ok   = req.valid && (count != CW'(QDEPTH)) && stall_ok && !reset;
        data_ok   = (count != '0) && (timer == 4'd0) && !reset;
        entry_dat = is_write ? 32'h0 : ram[widx];

        resp         = '0;
        resp.addr_ok = addr_ok;
        resp.data_ok = data_ok;
        resp.data    = data_ok ? q_dat[rptr] : 32'h0;
    end

    assign dresp   = resp;
    assign pending = count;

    // RAM contents survive reset.
    always_ff @(posedge clk) begin
        if (addr_ok && is_write) begin
            for (int i = 0; i < 4; i++) begin
                if (req.strobe[i]) begin
                    ram[widx][8*i +: 8] <= req.data[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (addr_ok) begin
            q_dat[wptr] <= entry_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            timer <= 4'(LATENCY - 1);
        end else begin
            if (addr_ok) begin
                wptr <= wptr + 1'b1;
            end
            if (data_ok) begin
                rptr <= rptr + 1'b1;
            end
            case ({addr_ok, data_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // A new head appears on a pop (successor promoted) or a push into an empty queue.
            if (data_ok || (addr_ok && count == '0)) begin
                timer <= 4'(LATENCY - 1);
            end else if (timer != 4'd0) begin
                timer <= timer - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dbus_scratchpad_responder.sv
// Directed bench for dbus_scratchpad_responder: three instances at LATENCY 2, 3 and 1.
module tb_dbus_scratchpad_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [71:0] dreq_a  [3];
    logic [33:0] dresp_a [3];
    logic [2:0]  pend_a  [3];
    logic        rst_a   [3];

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] rq0 [$];
    logic [31:0] rq1 [$];

    dbus_scratchpad_responder #(.AW(10), .LATENCY(2), .QDEPTH(4)) u_l2 (
        .clk(clk), .reset(rst_a[0]), .dreq(dreq_a[0]), .dresp(dresp_a[0]), .pending(pend_a[0])
    );
    dbus_scratchpad_responder #(.AW(10), .LATENCY(3), .QDEPTH(4)) u_l3 (
        .clk(clk), .reset(rst_a[1]), .dreq(dreq_a[1]), .dresp(dresp_a[1]), .pending(pend_a[1])
    );
    dbus_scratchpad_responder #(.AW(10), .LATENCY(1), .QDEPTH(4)) u_l1 (
        .clk(clk), .reset(rst_a[2]), .dreq(dreq_a[2]), .dresp(dresp_a[2]), .pending(pend_a[2])
    );

    always @(negedge clk) begin
        if (dresp_a[0][32]) rq0.push_back(dresp_a[0][31:0]);
        if (dresp_a[1][32]) rq1.push_back(dresp_a[1][31:0]);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [71:0] rd(input logic [31:0] a);
        return {1'b1, a, 3'b010, 4'h0, 32'h0};
    endfunction

    function automatic logic [71:0] wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        return {1'b1, a, 3'b010, s, d};
    endfunction

    // Drive one cycle's inputs just after the edge, then settle at the falling edge.
    task automatic step(input int w, input logic [71:0] r, input logic rs);
        @(posedge clk);
        #1;
        dreq_a[w] = r;
        rst_a[w]  = rs;
        @(negedge clk);
    endtask

    task automatic send(input int w, input logic [71:0] r, input string tag);
        int n;
        n = 0;
        step(w, r, 1'b0);
        while (!dresp_a[w][33] && n < 50) begin
            step(w, r, 1'b0);
            n++;
        end
        chk(tag, dresp_a[w][33], 1'b1);
    endtask

    task automatic idle_n(input int w, input int n);
        repeat (n) step(w, 72'h0, 1'b0);
    endtask

    initial begin
        logic [7:0]  aok_e;
        logic [7:0]  dok_e;
        logic [2:0]  pend_e [8];

        for (int i = 0; i < 3; i++) begin
            dreq_a[i] = 72'h0;
            rst_a[i]  = 1'b1;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) rst_a[i] = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_pending%0d", i), pend_a[i], 0);
            chk($sformatf("rst_dresp%0d", i), dresp_a[i][31:0] | {30'h0, dresp_a[i][33:32]}, 0);
        end

        // Write then read, LATENCY=2.
        step(0, wr(32'h40, 32'hDEADBEEF, 4'hF), 1'b0);
        chk("wr_aok_T", dresp_a[0][33], 1);
        chk("wr_dok_T", dresp_a[0][32], 0);
        step(0, rd(32'h40), 1'b0);
        chk("rd_aok_T1", dresp_a[0][33], 1);
        chk("rd_dok_T1", dresp_a[0][32], 0);
        step(0, 72'h0, 1'b0);
        chk("wr_dok_T2", dresp_a[0][32], 1);
        chk("wr_dat_T2", dresp_a[0][31:0], 32'h0);
        chk("pend_T2", pend_a[0], 2);
        step(0, 72'h0, 1'b0);
        chk("dok_T3", dresp_a[0][32], 0);
        step(0, 72'h0, 1'b0);
        chk("rd_dok_T4", dresp_a[0][32], 1);
        chk("rd_dat_T4", dresp_a[0][31:0], 32'hDEADBEEF);
        step(0, 72'h0, 1'b0);
        chk("dok_T5", dresp_a[0][32], 0);
        chk("pend_T5", pend_a[0], 0);

        // Byte strobes.
        idle_n(0, 2);
        rq0.delete();
        send(0, wr(32'h8, 32'h11223344, 4'hF), "bs_wr_full");
        send(0, wr(32'h8, 32'hAABBCCDD, 4'b0101), "bs_wr_part");
        send(0, rd(32'h8), "bs_rd");
        idle_n(0, 12);
        chk("bs_count", rq0.size(), 3);
        chk("bs_wr0_dat", rq0[0], 32'h0);
        chk("bs_wr1_dat", rq0[1], 32'h0);
        chk("bs_rd_dat", rq0[2], 32'h11BB33DD);

        // Address alias: upper bits ignored.
        rq0.delete();
        send(0, wr(32'h1000, 32'h12345678, 4'hF), "al_wr");
        send(0, rd(32'h0), "al_rd");
        idle_n(0, 8);
        chk("al_count", rq0.size(), 2);
        chk("al_rd_dat", rq0[1], 32'h12345678);

        // Ten requests through the queue, crossing pointer wrap.
        for (int i = 0; i < 10; i++) send(0, wr(32'h100 + 4 * i, 32'hC0DE0000 + i, 4'hF), "wp_wr");
        idle_n(0, 30);
        rq0.delete();
        for (int i = 0; i < 10; i++) send(0, rd(32'h100 + 4 * i), "wp_rd");
        idle_n(0, 30);
        chk("wp_count", rq0.size(), 10);
        for (int i = 0; i < 10; i++) chk($sformatf("wp_dat%0d", i), rq0[i], 32'hC0DE0000 + i);

        // Full queue, LATENCY=3: hold a read valid for 8 cycles.
        aok_e  = 8'b1001_1111;
        dok_e  = 8'b0100_1000;
        pend_e = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd4, 3'd4, 3'd3};
        for (int k = 0; k < 8; k++) begin
            step(1, rd(32'h20), 1'b0);
            chk($sformatf("fq_aok%0d", k), dresp_a[1][33], aok_e[k]);
            chk($sformatf("fq_dok%0d", k), dresp_a[1][32], dok_e[k]);
            chk($sformatf("fq_pend%0d", k), pend_a[1], pend_e[k]);
        end
        idle_n(1, 30);

        // Reset with three reads outstanding.
        rq1.delete();
        send(1, rd(32'h0), "mr_rd0");
        send(1, rd(32'h4), "mr_rd1");
        send(1, rd(32'h8), "mr_rd2");
        step(1, 72'h0, 1'b1);
        chk("mr_dok_in_reset", dresp_a[1][32], 0);
        step(1, rd(32'hC), 1'b0);
        chk("mr_aok_after", dresp_a[1][33], 1);
        chk("mr_pend_after", pend_a[1], 0);
        chk("mr_dok_after", dresp_a[1][32], 0);
        idle_n(1, 10);
        chk("mr_resp_count", rq1.size(), 1);

        // LATENCY=1 streaming.
        send(2, wr(32'h0, 32'hA5A50000, 4'hF), "st_wr0");
        send(2, wr(32'h4, 32'h5A5A1111, 4'hF), "st_wr1");
        idle_n(2, 5);
        for (int k = 0; k < 8; k++) begin
            step(2, rd(32'(4 * (k % 2))), 1'b0);
            chk($sformatf("st_aok%0d", k), dresp_a[2][33], 1);
            chk($sformatf("st_pend%0d", k), pend_a[2], (k == 0) ? 0 : 1);
            chk($sformatf("st_dok%0d", k), dresp_a[2][32], (k == 0) ? 0 : 1);
            if (k > 0)
                chk($sformatf("st_dat%0d", k), dresp_a[2][31:0],
                    ((k - 1) % 2 == 1) ? 32'h5A5A1111 : 32'hA5A50000);
        end
        step(2, 72'h0, 1'b0);
        chk("st_dok_last", dresp_a[2][32], 1);
        chk("st_dat_last", dresp_a[2][31:0], 32'h5A5A1111);
        step(2, 72'h0, 1'b0);
        chk("st_pend_end", pend_a[2], 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
